pet_vram_sched: RTL and testbench

// Slot scheduler for the shared 2 KB video RAM port. Divides each 1 MHz CPU cycle
// (32 subclocks, cnt31_i) into video-fetch, CPU and DMA slots; drives the VRAM

---
 rtl/pet_vram_sched.sv | 157 +++++++++++++++
 tb/tb_pet_vram_sched.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pet_vram_sched.sv
// pet_vram_sched: divides each 32-subclock CPU cycle of the shared video RAM
// port into video-fetch, CPU and DMA slots. All outputs are registered, so a
// decision taken while cnt31_i == N becomes visible on the following clk.
module pet_vram_sched #(
    parameter int VID_SLOT    = 3,   // first subclock of video fetch (+16 in 80-col)
    parameter int CPU_WR_SLOT = 8,   // subclock of the single CPU write strobe
    parameter int DMA_SLOT    = 12   // first subclock of the DMA slot
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] cnt31_i,
    input  logic       pref_have_80_cols,
    input  logic       pref_eoi_blanks,
    input  logic       cpu_sel,
    input  logic       cpu_we,
    input  logic       dma_req,
    input  logic       dma_we,
    output logic [1:0] vram_owner,
    output logic       vram_we,
    output logic       load_sr,
    output logic       ce_pixel,
    output logic       ce_8m,
    output logic       dma_ack,
    output logic       snow
);

    // Slots must be disjoint and fit inside one 32-subclock cycle.
    localparam bit SLOT_CLASH =
        (CPU_WR_SLOT >= VID_SLOT      && CPU_WR_SLOT <= VID_SLOT + 1)  ||
        (CPU_WR_SLOT >= VID_SLOT + 16 && CPU_WR_SLOT <= VID_SLOT + 17) ||
        (CPU_WR_SLOT >= DMA_SLOT      && CPU_WR_SLOT <= DMA_SLOT + 1)  ||
        (DMA_SLOT + 1 >= VID_SLOT      && DMA_SLOT <= VID_SLOT + 1)    ||
        (DMA_SLOT + 1 >= VID_SLOT + 16 && DMA_SLOT <= VID_SLOT + 17)   ||
        (VID_SLOT < 0) || (VID_SLOT + 18 > 31) ||
        (DMA_SLOT < 0) || (DMA_SLOT + 2 > 31)  ||
        (CPU_WR_SLOT < 0) || (CPU_WR_SLOT > 31);

    if (SLOT_CLASH) begin : g_slot_clash
        $error("pet_vram_sched: overlapping or out-of-range slot parameters");
    end

    localparam logic [4:0] V0  = 5'(VID_SLOT);
    localparam logic [4:0] V0N = 5'(VID_SLOT + 1);
    localparam logic [4:0] V0L = 5'(VID_SLOT + 2);
    localparam logic [4:0] V1  = 5'(VID_SLOT + 16);
    localparam logic [4:0] V1N = 5'(VID_SLOT + 17);
    localparam logic [4:0] V1L = 5'(VID_SLOT + 18);
    localparam logic [4:0] WS  = 5'(CPU_WR_SLOT);
    localparam logic [4:0] D0  = 5'(DMA_SLOT);

    typedef enum logic [1:0] {
        OWN_VIDEO = 2'd0,
        OWN_CPU   = 2'd1,
        OWN_DMA   = 2'd2
    } owner_e;

    // DMA_SLOT and DMA_ACK are only ever occupied on cnt D+1 and D+2.
    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_PEND,
        DMA_SLOT1,
        DMA_ACK
    } dma_state_e;

    dma_state_e dma_state, dma_next;
    logic       snow_pend;

    logic       video_slot, video_load, cpu_override;
    logic       dma_own, dma_write, dma_done;
    logic       snow_pend_next;
    owner_e     owner_next;
    logic       we_next, cep_next;

    // Slot decode for the current subclock.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        video_slot   = (cnt31_i == V0) || (cnt31_i == V0N) ||
                       (pref_have_80_cols && ((cnt31_i == V1) || (cnt31_i == V1N)));
        video_load   = (cnt31_i == V0L) || (pref_have_80_cols && (cnt31_i == V1L));
        cpu_override = video_slot && pref_eoi_blanks && cpu_sel;
        // Remember an override until the load point of the same fetch.
        snow_pend_next = video_load ? 1'b0 : (snow_pend | cpu_override);
        cep_next       = pref_have_80_cols ? cnt31_i[0] : (cnt31_i[1:0] == 2'd1);
    end

    // DMA request tracking: pending, slot taken on D and D+1, ack on D+2.
    always_comb begin
        dma_next  = dma_state;
        dma_own   = 1'b0;
        dma_write = 1'b0;
        dma_done  = 1'b0;
        case (dma_state)
            DMA_IDLE: begin
                if (dma_req) dma_next = DMA_PEND;
            end
            DMA_PEND: begin
                if (!dma_req) begin
                    dma_next = DMA_IDLE;
                end else if (cnt31_i == D0) begin
                    dma_own  = 1'b1;
                    dma_next = DMA_SLOT1;
                end
            end
            DMA_SLOT1: begin
                if (dma_req) begin
                    dma_own   = 1'b1;
                    dma_write = dma_we;
                    dma_next  = DMA_ACK;
                end else begin
                    dma_next = DMA_IDLE;
                end
            end
            DMA_ACK: begin
                dma_done = dma_req;
                dma_next = DMA_IDLE;
            end
        endcase
    end

    // Owner select and write strobe for the next clk.
    always_comb begin
        owner_next = OWN_CPU;
        if (video_slot && !cpu_override) begin
            owner_next = OWN_VIDEO;
        end else if (dma_own) begin
            owner_next = OWN_DMA;
        end
        we_next = dma_write || ((cnt31_i == WS) && cpu_sel && cpu_we);
    end

    // Output and state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            dma_state  <= DMA_IDLE;
            snow_pend  <= 1'b0;
            vram_owner <= OWN_CPU;
            vram_we    <= 1'b0;
            load_sr    <= 1'b0;
            ce_pixel   <= 1'b0;
            ce_8m      <= 1'b0;
            dma_ack    <= 1'b0;
            snow       <= 1'b0;
        end else begin
            dma_state  <= dma_next;
            snow_pend  <= snow_pend_next;
            vram_owner <= owner_next;
            vram_we    <= we_next;
            load_sr    <= video_load;
            ce_pixel   <= cep_next;
            ce_8m      <= (cnt31_i[1:0] == 2'd1);
            dma_ack    <= dma_done;
            snow       <= video_load && snow_pend;
        end
    end

endmodule

// File: tb/tb_pet_vram_sched.sv
// Directed bench for pet_vram_sched: the bench drives cnt31_i itself and
// checks every registered output one clk after each subclock value.
module tb_pet_vram_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] cnt31_i;
    logic       pref_have_80_cols, pref_eoi_blanks;
    logic       cpu_sel, cpu_we, dma_req, dma_we;
    logic [1:0] vram_owner;
    logic       vram_we, load_sr, ce_pixel, ce_8m, dma_ack, snow;

    int passed = 0;
    int total  = 0;

    pet_vram_sched dut (
        .clk               (clk),
        .reset             (reset),
        .cnt31_i           (cnt31_i),
        .pref_have_80_cols (pref_have_80_cols),
        .pref_eoi_blanks   (pref_eoi_blanks),
        .cpu_sel           (cpu_sel),
        .cpu_we            (cpu_we),
        .dma_req           (dma_req),
        .dma_we            (dma_we),
        .vram_owner        (vram_owner),
        .vram_we           (vram_we),
        .load_sr           (load_sr),
        .ce_pixel          (ce_pixel),
        .ce_8m             (ce_8m),
        .dma_ack           (dma_ack),
        .snow              (snow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int c, input logic [1:0] got, input logic [1:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s cnt=%0d observed=%0d expected=%0d", tag, c, got, exp);
    endtask

    // Apply one subclock value, clock it, sample 1 time unit after the edge.
    task automatic step(input int c);
        cnt31_i = 5'(c);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int c, input logic [1:0] e_owner, input bit e_we, input bit e_load,
                             input bit e_cep, input bit e_ce8, input bit e_ack, input bit e_snow);
        check("owner",    c, vram_owner,        e_owner);
        check("vram_we",  c, {1'b0, vram_we},   {1'b0, e_we});
        check("load_sr",  c, {1'b0, load_sr},   {1'b0, e_load});
        check("ce_pixel", c, {1'b0, ce_pixel},  {1'b0, e_cep});
        check("ce_8m",    c, {1'b0, ce_8m},     {1'b0, e_ce8});
        check("dma_ack",  c, {1'b0, dma_ack},   {1'b0, e_ack});
        check("snow",     c, {1'b0, snow},      {1'b0, e_snow});
    endtask

    // Run subclocks lo..hi with the expected pattern for the given scenario.
    // req_on/req_off raise/drop dma_req on that subclock; sel_at pulses cpu_sel.
    task automatic run_cycle(input int lo, input int hi, input bit e80, input bit e_cpuw,
                             input bit e_dma, input bit e_dmawe, input bit e_snow,
                             input int req_on, input int req_off, input int sel_at);
        for (int c = lo; c <= hi; c++) begin
            logic [1:0] eo;
            if (c == req_on)  dma_req = 1'b1;
            if (c == req_off) dma_req = 1'b0;
            if (sel_at >= 0)  cpu_sel = (c == sel_at);
            step(c);
            eo = 2'd1;
            if (c == 3 || c == 4 || (e80 && (c == 19 || c == 20))) eo = 2'd0;
            if (e_snow && c == 3) eo = 2'd1;
            if (e_dma && (c == 12 || c == 13)) eo = 2'd2;
            check_all(c, eo,
                      (e_cpuw && c == 8) || (e_dma && e_dmawe && c == 13),
                      (c == 5) || (e80 && c == 21),
                      e80 ? (c % 2 == 1) : (c % 4 == 1),
                      (c % 4 == 1),
                      e_dma && c == 14,
                      e_snow && c == 5);
        end
    endtask

    initial begin
        reset = 1'b1; cnt31_i = 5'd3;
        pref_have_80_cols = 1'b0; pref_eoi_blanks = 1'b0;
        cpu_sel = 1'b0; cpu_we = 1'b0; dma_req = 1'b0; dma_we = 1'b0;

        // Reset state, taken while cnt sits in a video slot.
        step(3);
        step(4);
        check_all(4, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // 40-col free run.
        run_cycle(0, 31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1);

        // 80-col free run.
        pref_have_80_cols = 1'b1;
        run_cycle(0, 31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1);
        pref_have_80_cols = 1'b0;

        // CPU selects and writes for the whole cycle: one strobe at cnt 8.
        cpu_sel = 1'b1; cpu_we = 1'b1;
        run_cycle(0, 31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1, -1);
        cpu_sel = 1'b0; cpu_we = 1'b0;

        // DMA write requested at cnt 2, released after the ack.
        dma_we = 1'b1;
        run_cycle(0, 31, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 15, -1);

        // DMA read requested at cnt 13 waits for the next CPU cycle.
        dma_we = 1'b0;
        run_cycle(0, 31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13, -1, -1);
        run_cycle(0, 31, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, 15, -1);

        // DMA request dropped before its slot: nothing happens.
        dma_we = 1'b1;
        run_cycle(0, 31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 11, -1);

        // 2001 mode: CPU hits VRAM at cnt 3 -> snow; DMA still served.
        pref_eoi_blanks = 1'b1; dma_we = 1'b0;
        run_cycle(0, 31, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2, 15, 3);
        pref_eoi_blanks = 1'b0; cpu_sel = 1'b0;

        // Reset at cnt 12 with a DMA write pending: no write, no ack.
        dma_we = 1'b1;
        run_cycle(0, 11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, -1, -1);
        reset = 1'b1;
        step(12);
        check_all(12, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0; dma_req = 1'b0;
        run_cycle(13, 31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
